framebuffer_port_arbiter: RTL and testbench
===========================================

Name: framebuffer_port_arbiter

Overview:
- Shares one single-port framebuffer RAM (76800 pixels, 320x240) between two requesters:
  - the camera capture writer;
  - the VGA display reader, which is driven by sync_pulse_generator pixel/video_en.
- Display reads have absolute priority so the scan-out never stalls.
- Camera writes are buffered in a small FIFO. They drain on cycles with no read request, mainly during horizontal and vertical blanking.

Parameters:
- ADDR_WIDTH, 17, framebuffer address width (= $clog2(76800)).
- DATA_WIDTH, 12, pixel width (RGB444).
- FIFO_DEPTH, 8, camera write FIFO entries; power of two, at least 2.
- MEM_LATENCY, 1, RAM read latency in cycles from mem_en_o to valid mem_data_i.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  asynchronous, active-low reset.
- cam_valid_i  in  1  camera write request.
- cam_addr_i  in  ADDR_WIDTH  camera write address.
- cam_data_i  in  DATA_WIDTH  camera write pixel.
- cam_ready_o  out  1  FIFO can accept a write; a push occurs when cam_valid_i && cam_ready_o.
- rd_req_i  in  1  display read request (one per pixel).
- rd_addr_i  in  ADDR_WIDTH  display read address.
- rd_valid_o  out  1  rd_data_o holds read data.
- rd_data_o  out  DATA_WIDTH  display read pixel.
- mem_en_o  out  1  RAM enable.
- mem_we_o  out  1  RAM write enable.
- mem_addr_o  out  ADDR_WIDTH  RAM address.
- mem_wdata_o  out  DATA_WIDTH  RAM write data.
- mem_rdata_i  in  DATA_WIDTH  RAM read data.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow_o  out  1  sticky flag: cam_valid_i was seen while cam_ready_o was low.

Behaviour:

Reset (reset_i=0, asynchronous):
- All outputs 0 except cam_ready_o=1.
- FIFO is emptied; grant state = IDLE; read pipeline is flushed.
- Reset asserted mid-operation discards any in-flight read (no rd_valid_o) and all buffered writes.

Grant FSM, one registered decision per cycle:
- States: IDLE, READ, WRITE.
- Next state = READ if rd_req_i; else WRITE if FIFO not empty; else IDLE.
- Memory outputs are registered from the decision:
  - READ: mem_en_o=1, mem_we_o=0, mem_addr_o=rd_addr_i.
  - WRITE: mem_en_o=1, mem_we_o=1, mem_addr_o/mem_wdata_o = FIFO head; the FIFO pops in the decision cycle.
  - IDLE: mem_en_o=0, mem_we_o=0; addr/data hold their last values.

Read latency:
- rd_req_i sampled at edge N -> mem_en_o at N+1 -> mem_rdata_i valid at N+1+MEM_LATENCY.
- That data is registered to rd_data_o with rd_valid_o=1 at N+2+MEM_LATENCY, i.e. fixed latency 3 at default.
- A valid-bit shift register tracks reads; back-to-back reads give a continuous rd_valid_o.
- rd_data_o holds its value when rd_valid_o=0.

FIFO:
- Synchronous with registered pointers; wrap-around at FIFO_DEPTH.
- cam_ready_o = !full, taken from registered state.
- A pushed entry is eligible for a write grant the cycle after the push.
- Simultaneous push and pop when not full: level unchanged.
- Pop when empty: never occurs (FSM guards it).
- Writes are issued in FIFO order.

Hazard:
- A read to an address that is still in the FIFO returns the old RAM contents; there is no forwarding.
- A read-after-write to the same address is coherent once the write has been issued to RAM.

Starvation and overflow:
- There is no starvation guard; continuous rd_req_i starves writes indefinitely.
- overflow_o sets when cam_valid_i=1 and cam_ready_o=0; the dropped pixel is discarded.
- overflow_o clears only on reset.

Arithmetic and limits:
- Addresses pass through unmodified; no range check against 76800.
- fifo_level_o range is 0..FIFO_DEPTH.

Test Plan:
1. Reset mid-read: reset_i low while 2 reads are in flight -> no rd_valid_o afterwards; fifo_level_o=0; cam_ready_o=1; mem_en_o=0.
2. Single read, RAM preloaded addr 100=12'hABC: rd_req_i at cycle N -> mem_addr_o=100 at N+1, rd_valid_o=1 with rd_data_o=12'hABC at N+3, one cycle wide.
3. Idle-bus write: push addr 5 data 12'h123, no reads -> mem_we_o=1, mem_addr_o=5 two edges after the push; a later read of 5 returns 12'h123.
4. Priority and drain: 8 pushes while rd_req_i is held high for 640 cycles -> no writes issued, cam_ready_o=0 at level 8; after rd_req_i drops, 8 consecutive writes issue in order and the level returns to 0.
5. Overflow: a 9th push attempt while full -> overflow_o=1 and stays 1; the FIFO contents are unchanged.
6. Full frame: 320x240 camera writes interleaved with sync_pulse_generator-driven reads (640x480 timing) -> overflow_o stays 0 with FIFO_DEPTH=8 when the camera writes at most one pixel per 4 cycles.

Source files
------------

// File: rtl/framebuffer_port_arbiter.sv
// Arbitrates a single-port framebuffer RAM between a buffered camera writer and
// a display reader; display reads always win, camera writes drain from a FIFO.

module framebuffer_port_arbiter_checker #(
    parameter int LVL_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             mem_en_o,
    input  logic             mem_we_o,
    input  logic [LVL_W-1:0] fifo_level_o
);
    a_level_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
        fifo_level_o <= LVL_W'(FIFO_DEPTH));

    a_we_needs_en: assert property (@(posedge clk_i) disable iff (!reset_i)
        mem_we_o |-> mem_en_o);
endmodule

module framebuffer_port_arbiter #(
    parameter int ADDR_WIDTH  = 17,
    parameter int DATA_WIDTH  = 12,
    parameter int FIFO_DEPTH  = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        cam_valid_i,
    input  logic [ADDR_WIDTH-1:0]       cam_addr_i,
    input  logic [DATA_WIDTH-1:0]       cam_data_i,
    output logic                        cam_ready_o,
    input  logic                        rd_req_i,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
    output logic                        rd_valid_o,
    output logic [DATA_WIDTH-1:0]       rd_data_o,
    output logic                        mem_en_o,
    output logic                        mem_we_o,
    output logic [ADDR_WIDTH-1:0]       mem_addr_o,
    output logic [DATA_WIDTH-1:0]       mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]       mem_rdata_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        overflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [ENT_W-1:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [ADDR_WIDTH-1:0]  w_head_addr;
    logic [DATA_WIDTH-1:0]  w_head_data;
    logic                   r_mem_en;
    logic                   r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_wdata;
    logic [MEM_LATENCY-1:0] r_rd_pipe;
    logic                   r_rd_valid;
    logic [DATA_WIDTH-1:0]  r_rd_data;
    logic                   r_overflow;

    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == {LVL_W{1'b0}});
    assign w_push  = cam_valid_i && !w_full;
    assign w_pop   = (w_next_state == ST_WRITE);
    assign {w_head_addr, w_head_data} = r_fifo_mem[r_rd_ptr];

    // Grant decision: reads first, then pending camera writes, else idle.
    always_comb begin
        w_next_state = ST_IDLE;
        if (rd_req_i) begin
            w_next_state = ST_READ;
        end else if (!w_empty) begin
            w_next_state = ST_WRITE;
        end else begin
            w_next_state = ST_IDLE;
        end
    end

    // Grant state register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Camera write FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= {ENT_W{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {cam_addr_i, cam_data_i};
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // RAM command registers; address and data hold while idle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {ADDR_WIDTH{1'b0}};
            r_mem_wdata <= {DATA_WIDTH{1'b0}};
        end else begin
            case (w_next_state)
                ST_READ: begin
                    r_mem_en   <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= rd_addr_i;
                end
                ST_WRITE: begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_head_addr;
                    r_mem_wdata <= w_head_data;
                end
                ST_IDLE: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
                default: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Read tracking: bit k set means a read was presented to RAM k+1 cycles ago.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_pipe  <= {MEM_LATENCY{1'b0}};
            r_rd_valid <= 1'b0;
            r_rd_data  <= {DATA_WIDTH{1'b0}};
        end else begin
            r_rd_pipe <= (r_rd_pipe << 1'b1) | MEM_LATENCY'(r_state == ST_READ);
            if (r_rd_pipe[MEM_LATENCY-1]) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= mem_rdata_i;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow: a camera pixel offered while the FIFO was full.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_overflow <= 1'b0;
        end else if (cam_valid_i && w_full) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign cam_ready_o  = !w_full;
    assign fifo_level_o = r_level;
    assign mem_en_o     = r_mem_en;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;
    assign rd_valid_o   = r_rd_valid;
    assign rd_data_o    = r_rd_data;
    assign overflow_o   = r_overflow;

    framebuffer_port_arbiter_checker #(
        .LVL_W      (LVL_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_checker (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .fifo_level_o (fifo_level_o)
    );
endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
// Bench for framebuffer_port_arbiter: RAM model, queue-based reference model,
// a vector table, hand sequences for reset/priority/overflow, and a display scan.

module tb_framebuffer_port_arbiter;
    localparam int AW    = 17;
    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          clk_i       = 1'b0;
    logic          reset_i     = 1'b0;
    logic          cam_valid_i = 1'b0;
    logic [AW-1:0] cam_addr_i  = '0;
    logic [DW-1:0] cam_data_i  = '0;
    logic          cam_ready_o;
    logic          rd_req_i    = 1'b0;
    logic [AW-1:0] rd_addr_i   = '0;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic [LW-1:0] fifo_level_o;
    logic          overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    framebuffer_port_arbiter dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cam_valid_i  (cam_valid_i),
        .cam_addr_i   (cam_addr_i),
        .cam_data_i   (cam_data_i),
        .cam_ready_o  (cam_ready_o),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .fifo_level_o (fifo_level_o),
        .overflow_o   (overflow_o)
    );

    initial forever #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 37 + 11);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Single-port RAM, one cycle read latency, preloaded with a known pattern.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = pat(i);
        ram[100] = 12'hABC;
        forever begin
            @(posedge clk_i);
            if (mem_en_o) begin
                if (mem_we_o) ram[mem_addr_o] = mem_wdata_o;
                else          mem_rdata_i <= ram[mem_addr_o];
            end
        end
    end

    // Reference model: pending writes are a queue, RAM contents an array.
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { longint due; logic [DW-1:0] d; } rd_t;
    wr_t           m_q [$];
    rd_t           m_rd [$];
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    bit            m_en = 1'b0, m_we = 1'b0, m_rv = 1'b0, m_ovf = 1'b0, m_pend = 1'b0;
    logic [AW-1:0] m_addr = '0, m_pend_a = '0;
    logic [DW-1:0] m_wdata = '0, m_rd_data = '0, m_pend_d = '0;
    longint        cyc = 0;

    initial begin
        int  sz;
        wr_t w;
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = pat(i);
        m_mem[100] = 12'hABC;
        forever begin
            @(posedge clk_i or negedge reset_i);
            if (!reset_i) begin
                m_q.delete(); m_rd.delete();
                m_en = 0; m_we = 0; m_rv = 0; m_ovf = 0; m_pend = 0;
                m_addr = '0; m_wdata = '0; m_rd_data = '0;
            end else begin
                cyc++;
                if (m_pend) begin
                    m_mem[m_pend_a] = m_pend_d;
                    m_pend = 0;
                end
                sz = m_q.size();
                if (rd_req_i) begin
                    m_en = 1; m_we = 0; m_addr = rd_addr_i;
                    m_rd.push_back('{cyc + 2, m_mem[rd_addr_i]});
                end else if (sz > 0) begin
                    w = m_q.pop_front();
                    m_en = 1; m_we = 1; m_addr = w.a; m_wdata = w.d;
                    m_pend = 1; m_pend_a = w.a; m_pend_d = w.d;
                end else begin
                    m_en = 0; m_we = 0;
                end
                if (cam_valid_i) begin
                    if (sz < DEPTH) m_q.push_back('{cam_addr_i, cam_data_i});
                    else            m_ovf = 1;
                end
                m_rv = 0;
                if (m_rd.size() > 0 && m_rd[0].due == cyc) begin
                    m_rv = 1;
                    m_rd_data = m_rd[0].d;
                    void'(m_rd.pop_front());
                end
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk_i);
        chk("level",     32'(fifo_level_o), 32'(m_q.size()));
        chk("cam_ready", 32'(cam_ready_o),  32'(m_q.size() < DEPTH));
        chk("overflow",  32'(overflow_o),   32'(m_ovf));
        chk("mem_en",    32'(mem_en_o),     32'(m_en));
        chk("mem_we",    32'(mem_we_o),     32'(m_we));
        chk("mem_addr",  32'(mem_addr_o),   32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata_o),  32'(m_wdata));
        chk("rd_valid",  32'(rd_valid_o),   32'(m_rv));
        chk("rd_data",   32'(rd_data_o),    32'(m_rd_data));
    end

    typedef struct {
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [5];

    initial begin
        int seen;
        int since;
        int fa;
        vecs[0] = '{17'd5,      12'h123, 17'd5,      12'h123};
        vecs[1] = '{17'd200,    12'h7F0, 17'd200,    12'h7F0};
        vecs[2] = '{17'd300,    12'h001, 17'd301,    pat(301)};
        vecs[3] = '{17'd131071, 12'hFFF, 17'd131071, 12'hFFF};
        vecs[4] = '{17'd0,      12'h555, 17'd0,      12'h555};

        repeat (3) tick();
        @(negedge clk_i); #1 reset_i = 1'b1;
        tick();

        // Reset while two reads are in flight.
        rd_req_i = 1'b1; rd_addr_i = 17'd10; tick();
        rd_addr_i = 17'd11; tick();
        rd_req_i = 1'b0;
        #1 reset_i = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(rd_valid_o),   32'd0);
        chk("rst_level",    32'(fifo_level_o), 32'd0);
        chk("rst_ready",    32'(cam_ready_o),  32'd1);
        chk("rst_mem_en",   32'(mem_en_o),     32'd0);
        tick(); tick();
        @(negedge clk_i); #1 reset_i = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rd_valid_o) seen++;
        end
        chk("rst_no_rd_valid", 32'(seen), 32'd0);

        // Single read of preloaded address 100.
        rd_req_i = 1'b1; rd_addr_i = 17'd100; tick();
        rd_req_i = 1'b0;
        chk("rd_mem_addr", 32'(mem_addr_o), 32'd100);
        chk("rd_mem_en",   32'(mem_en_o),   32'd1);
        chk("rd_mem_we",   32'(mem_we_o),   32'd0);
        tick(); chk("rd_valid_early", 32'(rd_valid_o), 32'd0);
        tick(); chk("rd_valid_n3",    32'(rd_valid_o), 32'd1);
                chk("rd_data_n3",     32'(rd_data_o),  32'hABC);
        tick(); chk("rd_valid_width", 32'(rd_valid_o), 32'd0);

        // Vector table: idle-bus write, then read back.
        foreach (vecs[k]) begin
            cam_valid_i = 1'b1; cam_addr_i = vecs[k].ca; cam_data_i = vecs[k].cd;
            tick();
            cam_valid_i = 1'b0;
            chk("vec_level1", 32'(fifo_level_o), 32'd1);
            chk("vec_no_we",  32'(mem_we_o),     32'd0);
            tick();
            chk("vec_we",    32'(mem_we_o),    32'd1);
            chk("vec_waddr", 32'(mem_addr_o),  32'(vecs[k].ca));
            chk("vec_wdata", 32'(mem_wdata_o), 32'(vecs[k].cd));
            tick(); tick();
            rd_req_i = 1'b1; rd_addr_i = vecs[k].ra; tick();
            rd_req_i = 1'b0;
            tick(); tick();
            chk("vec_rvalid", 32'(rd_valid_o), 32'd1);
            chk("vec_rdata",  32'(rd_data_o),  32'(vecs[k].exp));
            tick();
        end

        // Reads starve writes; FIFO fills, then a 9th push overflows.
        seen = 0;
        rd_req_i = 1'b1;
        for (int i = 0; i < 640; i++) begin
            rd_addr_i   = AW'($urandom_range(0, 76799));
            cam_valid_i = (i < 8) || (i == 300);
            cam_addr_i  = (i == 300) ? 17'd2000 : AW'(1000 + i);
            cam_data_i  = (i == 300) ? 12'hFFF : DW'(12'h800 + i);
            if (i == 300) chk("ovf_before", 32'(overflow_o), 32'd0);
            tick();
            if (mem_we_o) seen++;
            if (i == 300) begin
                chk("ovf_set",   32'(overflow_o),   32'd1);
                chk("ovf_level", 32'(fifo_level_o), 32'd8);
            end
        end
        cam_valid_i = 1'b0;
        chk("starve_no_writes", 32'(seen),         32'd0);
        chk("full_level",       32'(fifo_level_o), 32'd8);
        chk("full_not_ready",   32'(cam_ready_o),  32'd0);
        rd_req_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("drain_we",    32'(mem_we_o),    32'd1);
            chk("drain_addr",  32'(mem_addr_o),  32'(1000 + k));
            chk("drain_wdata", 32'(mem_wdata_o), 32'(12'h800 + k));
        end
        tick();
        chk("drain_level",  32'(fifo_level_o), 32'd0);
        chk("drain_idle",   32'(mem_en_o),     32'd0);
        chk("ovf_sticky",   32'(overflow_o),   32'd1);

        // Randomized traffic over a small address window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            rd_req_i    = ($urandom_range(0, 2) == 0);
            rd_addr_i   = AW'($urandom_range(0, 15));
            cam_valid_i = $urandom_range(0, 1) == 1;
            cam_addr_i  = AW'($urandom_range(0, 15));
            cam_data_i  = DW'($urandom);
            tick();
        end
        rd_req_i = 1'b0; cam_valid_i = 1'b0;
        #1 reset_i = 1'b0;
        tick();
        @(negedge clk_i); #1 reset_i = 1'b1;
        tick();
        chk("ovf_cleared", 32'(overflow_o), 32'd0);

        // Display scan (pixel strobe every 4 clocks) against paced camera writes.
        since = 4;
        fa = 0;
        for (int v = 470; v < 494; v++) begin
            for (int h = 0; h < 800; h++) begin
                for (int s = 0; s < 4; s++) begin
                    rd_req_i  = (s == 0) && (h < 640) && (v < 480);
                    rd_addr_i = AW'((v / 2) * 320 + h / 2);
                    since++;
                    cam_valid_i = 1'b0;
                    if (since >= 4 && $urandom_range(0, 1) == 1) begin
                        cam_valid_i = 1'b1;
                        cam_addr_i  = AW'(fa);
                        cam_data_i  = DW'($urandom);
                        fa    = (fa + 1) % 76800;
                        since = 0;
                    end
                    tick();
                end
            end
        end
        rd_req_i = 1'b0; cam_valid_i = 1'b0;
        repeat (12) tick();
        chk("frame_no_overflow", 32'(overflow_o),   32'd0);
        chk("frame_drained",     32'(fifo_level_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
